// File: rtl/multiphase_nco_pkg.sv
// multiphase_nco_pkg
// Shared types and constant helpers for the multiphase NCO.
//   nco_state_e : controller states (IDLE, RUN, PEND)
//   phase_off   : accumulator offset of phase k, floor(k*2^acc_w/num_phases)
//   inc_of      : accumulator increment for a code, base*(code+1) mod 2^acc_w
package multiphase_nco_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } nco_state_e;

    function automatic longint unsigned phase_off(input int k, input int num_phases,
                                                  input int acc_w);
        longint unsigned span;
        span = longint'(k) << acc_w;
        return span / longint'(num_phases);
    endfunction

    function automatic longint unsigned inc_of(input longint unsigned code,
                                               input longint unsigned base_inc,
                                               input int acc_w);
        return (base_inc * (code + 64'd1)) % (64'd1 << acc_w);
    endfunction

endpackage

// File: rtl/multiphase_nco_ctrl_settle.sv
// ctrl_settle
// Debounces the requested frequency code and holds the next code to adopt.
//   clk, rst_n    : clock, synchronous active-low reset
//   ctrl          : raw requested code
//   active_ctrl   : code currently driving the accumulator
//   clr           : adoption strobe from the controller, retires pend
//   pend, pend_v  : settled code awaiting adoption and its valid flag
module ctrl_settle
    import multiphase_nco_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [CTRL_W-1:0] active_ctrl,
    input  logic              clr,
    output logic [CTRL_W-1:0] pend,
    output logic              pend_v
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SAT = CNT_W'(SETTLE - 1);

    logic [CTRL_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic              settled;

    always_comb begin
        cand_d   = ctrl;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        settled  = (cnt_q == SAT) && (cand_q == ctrl);

        if (ctrl != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (clr) begin
            pend_v_d = 1'b0;
        end
        // A settled code that matches what is (or is about to be) active
        // cancels any pending request; a different one replaces it, even on
        // the adoption edge, so it arms the following wrap.
        if (settled) begin
            if ((cand_q == active_ctrl) || (clr && (cand_q == pend_q))) begin
                pend_v_d = 1'b0;
            end else begin
                pend_d   = cand_q;
                pend_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    assign pend   = pend_q;
    assign pend_v = pend_v_q;

endmodule

// File: rtl/multiphase_nco.sv
// multiphase_nco
// Phase-accumulator oscillator producing NUM_PHASES evenly spaced square
// waves. Frequency codes are debounced and only switched at an accumulator
// wrap so the outputs never glitch.
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : run enable (low parks accumulator and outputs at 0)
//   ctrl         : requested frequency code
//   out          : registered phase outputs, out[0] leads
//   active_ctrl  : code in use
//   switched     : one-cycle pulse when active_ctrl changes
//   busy         : a settled code is waiting for adoption
//
// state | meaning
// IDLE  | disabled; acc/out held at 0, pending code adopted at once
// RUN   | accumulating, nothing pending
// PEND  | accumulating, pending code adopted on the next carry
module multiphase_nco
    import multiphase_nco_pkg::*;
#(
    parameter int NUM_PHASES = 5,
    parameter int CTRL_W     = 2,
    parameter int ACC_W      = 16,
    parameter int BASE_INC   = 64,
    parameter int SETTLE     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CTRL_W-1:0]     ctrl,
    output logic [NUM_PHASES-1:0] out,
    output logic [CTRL_W-1:0]     active_ctrl,
    output logic                  switched,
    output logic                  busy
);

    nco_state_e            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [NUM_PHASES-1:0] out_q, out_d;
    logic [CTRL_W-1:0]     active_q, active_d;
    logic                  switched_q, switched_d;

    logic [ACC_W-1:0]      inc_tab [2**CTRL_W];
    logic [ACC_W-1:0]      inc_cur;
    logic [ACC_W-1:0]      acc_nxt;
    logic                  carry;
    logic [NUM_PHASES-1:0] phase_w;
    logic [CTRL_W-1:0]     pend;
    logic                  pend_v;
    logic                  adopt;

    for (genvar c = 0; c < 2**CTRL_W; c++) begin : g_inc
        assign inc_tab[c] = ACC_W'(inc_of(64'(c), 64'(BASE_INC), ACC_W));
    end

    assign inc_cur          = inc_tab[active_q];
    assign {carry, acc_nxt} = {1'b0, acc_q} + {1'b0, inc_cur};

    // Phase k is high for the half cycle starting at its offset: the MSB of
    // (acc - OFF_k) is clear exactly when that modular distance is < 2^(ACC_W-1).
    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
        localparam logic [ACC_W-1:0] OFF = ACC_W'(phase_off(k, NUM_PHASES, ACC_W));
        logic [ACC_W-1:0] rel;
        assign rel        = acc_nxt - OFF;
        assign phase_w[k] = ~rel[ACC_W-1];
    end

    assign adopt = pend_v && ((state_q == IDLE) || ((state_q == PEND) && en && carry));

    ctrl_settle #(
        .CTRL_W (CTRL_W),
        .SETTLE (SETTLE)
    ) u_settle (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl        (ctrl),
        .active_ctrl (active_q),
        .clr         (adopt),
        .pend        (pend),
        .pend_v      (pend_v)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_d      = out_q;
        active_d   = adopt ? pend : active_q;
        switched_d = adopt;

        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            out_d   = '0;
        end else begin
            // The wrap edge still advances with the old increment.
            acc_d = acc_nxt;
            out_d = phase_w;
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (pend_v) state_d = PEND;
                PEND:    if (adopt || !pend_v) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            out_q      <= '0;
            active_q   <= '0;
            switched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            active_q   <= active_d;
            switched_q <= switched_d;
        end
    end

    assign out         = out_q;
    assign active_ctrl = active_q;
    assign switched    = switched_q;
    assign busy        = pend_v;

endmodule
